// File: rtl/mem_types.sv
// Shared types for the data-memory responder: access sizes, FSM states, wait-state limit.
package mem_types;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10,
        MEM_RSVD = 2'b11
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam int MAX_WAIT_CYCLES = 15;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: store byte-enables/replicated write word, load extract + extension.
// Zero latency; no flow control of its own.
module mem_lane_align
    import mem_types::*;
(
    input  mem_size_t   size,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic        is_unsigned,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wword,
    output logic [31:0] rdata
);

    logic [31:0] byte_sh;
    logic [15:0] half_sel;

    assign byte_sh  = rword >> {lane, 3'b000};
    assign half_sel = lane[1] ? rword[31:16] : rword[15:0];

    // Write data is replicated across lanes so byte_en alone picks the target lane(s).
    always_comb begin
        byte_en = 4'b0000;
        wword   = wdata;
        rdata   = 32'd0;
        case (size)
            MEM_BYTE: begin
                byte_en = 4'b0001 << lane;
                wword   = {4{wdata[7:0]}};
                rdata   = is_unsigned ? {24'd0, byte_sh[7:0]}
                                      : {{24{byte_sh[7]}}, byte_sh[7:0]};
            end
            MEM_HALF: begin
                byte_en = lane[1] ? 4'b1100 : 4'b0011;
                wword   = {2{wdata[15:0]}};
                rdata   = is_unsigned ? {16'd0, half_sel}
                                      : {{16{half_sel[15]}}, half_sel};
            end
            MEM_WORD: begin
                byte_en = 4'b1111;
                wword   = wdata;
                rdata   = rword;
            end
            default: begin
                byte_en = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder over a word-organised array; response WAIT_CYCLES+1 edges after acceptance.
// One transaction in flight; req_ready only in IDLE, response held until rsp_ready.
module dmem_responder
    import mem_types::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int WAIT_EFF = (WAIT_CYCLES > MAX_WAIT_CYCLES) ? MAX_WAIT_CYCLES : WAIT_CYCLES;
    localparam logic [3:0] WAIT_LOAD = (WAIT_EFF > 0) ? 4'(WAIT_EFF - 1) : 4'd0;

    dmem_state_t state;
    logic [3:0]  cnt;
    logic        wr_q, uns_q, err_q;
    logic [31:0] addr_q, wdata_q, rd_word;
    mem_size_t   size_q;
    logic [31:0] mem [DEPTH_WORDS];

    logic        in_idle, accept, enter_resp;
    logic        cur_write, cur_unsigned, cur_fault;
    logic [31:0] cur_addr, cur_wdata, cur_off;
    mem_size_t   cur_size;
    logic [AW-1:0] idx;
    logic [3:0]  byte_en;
    logic [31:0] wword, ld_data;

    // In IDLE the live request drives the datapath so WAIT_CYCLES=0 can commit on the accepting edge.
    assign in_idle      = (state == IDLE);
    assign cur_write    = in_idle ? req_write    : wr_q;
    assign cur_addr     = in_idle ? req_addr     : addr_q;
    assign cur_wdata    = in_idle ? req_wdata    : wdata_q;
    assign cur_unsigned = in_idle ? req_unsigned : uns_q;
    assign cur_size     = in_idle ? mem_size_t'(req_size) : size_q;
    assign cur_off      = cur_addr - BASE_ADDR;
    assign idx          = cur_off[AW+1:2];

    // BASE_ADDR is aligned, so offset low bits equal address low bits; unsigned wrap catches below-base.
    assign cur_fault = (cur_size == MEM_RSVD)
                    || (cur_size == MEM_HALF && cur_off[0])
                    || (cur_size == MEM_WORD && cur_off[1:0] != 2'b00)
                    || (cur_off[31:AW+2] != '0);

    assign accept     = in_idle && req_valid && req_ready;
    assign enter_resp = (accept && WAIT_EFF == 0) || (state == WAIT && cnt == 4'd0);

    mem_lane_align u_align (
        .size        (cur_size),
        .lane        (cur_off[1:0]),
        .wdata       (cur_wdata),
        .is_unsigned (cur_unsigned),
        .rword       (rd_word),
        .byte_en     (byte_en),
        .wword       (wword),
        .rdata       (ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            wr_q      <= 1'b0;
            uns_q     <= 1'b0;
            err_q     <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            size_q    <= MEM_BYTE;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= !accept;
                    if (accept) begin
                        wr_q    <= req_write;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        size_q  <= mem_size_t'(req_size);
                        uns_q   <= req_unsigned;
                        err_q   <= cur_fault;
                        if (WAIT_EFF == 0) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                        end else begin
                            state <= WAIT;
                            cnt   <= WAIT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b0;
                end
            endcase
        end
    end

    // Array is deliberately outside the reset domain; contents survive rst_n.
    always_ff @(posedge clk) begin
        if (enter_resp) begin
            rd_word <= mem[idx];
            if (cur_write && !cur_fault) begin
                for (int i = 0; i < 4; i++) begin
                    if (byte_en[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
                end
            end
        end
    end

    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = (rsp_valid && !err_q && !wr_q) ? ld_data : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (WAIT_CYCLES=1 and 4) sharing request/reset stimulus.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid1, req_valid4;
    logic        req_write;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        rsp_ready;

    logic        rr1, rv1, re1, rr4, rv4, re4;
    logic [31:0] rd1, rd4;

    logic        sel;
    logic        m_rr, m_rv;

    always #5 clk = ~clk;

    assign m_rr = sel ? rr4 : rr1;
    assign m_rv = sel ? rv4 : rv1;

    dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid1), .req_ready(rr1), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .rsp_valid(rv1), .rsp_ready(rsp_ready), .rsp_rdata(rd1), .rsp_err(re1)
    );

    dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_CYCLES(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid4), .req_ready(rr4), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .rsp_valid(rv4), .rsp_ready(rsp_ready), .rsp_rdata(rd4), .rsp_err(re4)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  sz;
        logic        u;
        logic [31:0] er;
        logic        ee;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[$];
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic pop_check(input string name, input logic [31:0] rd, input logic re);
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s unexpected response actual=%h/%0d required=none", name, rd, re);
        end else begin
            e = sb_q.pop_front();
            check({name, "_rdata"}, rd, e.rdata);
            check({name, "_err"}, {31'd0, re}, {31'd0, e.err});
        end
    endtask

    // A response is consumed on the posedge following a negedge where valid&&ready are both high.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && rsp_ready) begin
            if (rv1) pop_check("rsp_w1", rd1, re1);
            if (rv4) pop_check("rsp_w4", rd4, re4);
        end
    end

    task automatic drive_req(input logic s, input logic w, input logic [31:0] a, input logic [31:0] d,
                             input logic [1:0] sz, input logic u);
        sel          = s;
        req_write    = w;
        req_addr     = a;
        req_wdata    = d;
        req_size     = sz;
        req_unsigned = u;
        if (s) req_valid4 = 1'b1;
        else   req_valid1 = 1'b1;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!m_rr && n < 30);
        if (!m_rr) check({name, "_ready_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic do_txn(input logic s, input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] sz, input logic u, input logic [31:0] er, input logic ee,
                          input string name);
        int lat;
        sb_q.push_back('{rdata: er, err: ee});
        @(posedge clk); #1;
        drive_req(s, w, a, d, sz, u);
        wait_ready(name);
        @(posedge clk); #1;
        req_valid1 = 1'b0;
        req_valid4 = 1'b0;
        lat = 1;
        forever begin
            @(negedge clk);
            if (m_rv || lat > 40) break;
            lat++;
        end
        check({name, "_latency"}, 32'(lat), s ? 32'd5 : 32'd2);
        @(posedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs.push_back('{1'b1, 32'h0000, 32'h0BADF00D, 2'b10, 1'b0, 32'h0,        1'b0});
        vecs.push_back('{1'b1, 32'h0010, 32'hDEADBEEF, 2'b10, 1'b0, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h0010, 32'h0,        2'b10, 1'b0, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b0, 32'h0013, 32'h0,        2'b00, 1'b0, 32'hFFFFFFDE, 1'b0});
        vecs.push_back('{1'b0, 32'h0013, 32'h0,        2'b00, 1'b1, 32'h000000DE, 1'b0});
        vecs.push_back('{1'b0, 32'h0010, 32'h0,        2'b01, 1'b0, 32'hFFFFBEEF, 1'b0});
        vecs.push_back('{1'b0, 32'h0012, 32'h0,        2'b01, 1'b1, 32'h0000DEAD, 1'b0});
        vecs.push_back('{1'b0, 32'h0012, 32'h0,        2'b01, 1'b0, 32'hFFFFDEAD, 1'b0});
        vecs.push_back('{1'b1, 32'h0011, 32'hFFFFFF55, 2'b00, 1'b0, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h0010, 32'h0,        2'b10, 1'b0, 32'hDEAD55EF, 1'b0});
        vecs.push_back('{1'b0, 32'h0012, 32'h0,        2'b10, 1'b0, 32'h0,        1'b1});
        vecs.push_back('{1'b0, 32'h0010, 32'h0,        2'b11, 1'b0, 32'h0,        1'b1});
        vecs.push_back('{1'b0, 32'h0011, 32'h0,        2'b01, 1'b0, 32'h0,        1'b1});
        vecs.push_back('{1'b1, 32'h1000, 32'hAAAAAAAA, 2'b10, 1'b0, 32'h0,        1'b1});
        vecs.push_back('{1'b1, 32'hFFFFFFFC, 32'h55555555, 2'b10, 1'b0, 32'h0,    1'b1});
        vecs.push_back('{1'b0, 32'h0000, 32'h0,        2'b10, 1'b0, 32'h0BADF00D, 1'b0});
        vecs.push_back('{1'b1, 32'h0002, 32'h1234ABCD, 2'b01, 1'b0, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h0000, 32'h0,        2'b10, 1'b0, 32'hABCDF00D, 1'b0});
        vecs.push_back('{1'b0, 32'h0001, 32'h0,        2'b00, 1'b0, 32'hFFFFFFF0, 1'b0});
        vecs.push_back('{1'b1, 32'h0FFC, 32'h13579BDF, 2'b10, 1'b0, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h0FFC, 32'h0,        2'b10, 1'b0, 32'h13579BDF, 1'b0});

        rst_n = 1'b0;
        sel = 1'b0;
        req_valid1 = 1'b0;
        req_valid4 = 1'b0;
        req_write = 1'b0;
        req_addr = 32'd0;
        req_wdata = 32'd0;
        req_size = 2'b00;
        req_unsigned = 1'b0;
        rsp_ready = 1'b1;

        // Reset values, then req_ready rising on the first edge after release
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", {31'd0, rr1}, 32'd0);
        check("rst_rsp_valid", {31'd0, rv1}, 32'd0);
        check("rst_rsp_rdata", rd1, 32'd0);
        check("rst_rsp_err", {31'd0, re1}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_before_edge", {31'd0, rr1}, 32'd0);
        @(negedge clk);
        check("ready_after_edge", {31'd0, rr1}, 32'd1);

        foreach (vecs[i]) begin
            do_txn(1'b0, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].sz, vecs[i].u,
                   vecs[i].er, vecs[i].ee, $sformatf("vec%0d", i));
        end

        // Backpressure with a second request queued behind the first
        sb_q.push_back('{rdata: 32'hDEAD55EF, err: 1'b0});
        sb_q.push_back('{rdata: 32'h000000EF, err: 1'b0});
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        drive_req(1'b0, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
        wait_ready("bp_first");
        @(posedge clk); #1;
        drive_req(1'b0, 1'b0, 32'h10, 32'h0, 2'b00, 1'b1);
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!rv1 && n < 30);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("bp_valid%0d", k), {31'd0, rv1}, 32'd1);
            check($sformatf("bp_rdata%0d", k), rd1, 32'hDEAD55EF);
            check($sformatf("bp_err%0d", k), {31'd0, re1}, 32'd0);
            check($sformatf("bp_ready%0d", k), {31'd0, rr1}, 32'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_ready_after_hs", {31'd0, rr1}, 32'd1);
        check("bp_valid_after_hs", {31'd0, rv1}, 32'd0);
        @(posedge clk); #1;
        req_valid1 = 1'b0;
        @(negedge clk);
        check("bp_queued_accepted", {31'd0, rr1}, 32'd0);
        begin
            int n = 0;
            while (!rv1 && n < 30) begin
                @(negedge clk);
                n++;
            end
            check("bp_second_rsp_seen", {31'd0, rv1}, 32'd1);
        end
        @(posedge clk);

        // WAIT_CYCLES=4: known contents at 0x20, then reset in the middle of a store's wait
        do_txn(1'b1, 1'b1, 32'h20, 32'h11111111, 2'b10, 1'b0, 32'h0, 1'b0, "w4_store");
        do_txn(1'b1, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 32'h11111111, 1'b0, "w4_load");
        @(posedge clk); #1;
        drive_req(1'b1, 1'b1, 32'h20, 32'h12345678, 2'b10, 1'b0);
        wait_ready("w4_abort");
        @(posedge clk); #1;
        req_valid4 = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("midrst_req_ready", {31'd0, rr4}, 32'd0);
        check("midrst_rsp_valid", {31'd0, rv4}, 32'd0);
        check("midrst_rsp_rdata", rd4, 32'd0);
        check("midrst_rsp_err", {31'd0, re4}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("midrst_no_rsp", {31'd0, rv4}, 32'd0);
        end
        do_txn(1'b1, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 32'h11111111, 1'b0, "w4_after_rst");

        repeat (3) @(posedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
